bullet_engine: RTL and testbench

BULLET_ENGINE -- requirements
Module: bullet_engine

---
 rtl/bullet_engine.sv | 206 ++++++++++++++++++++
 tb/tb_bullet_engine.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_engine.sv
// Single-bullet engine: spawns from the tank on a fire edge and steps once per frame.
// Each step checks the destination tile, then moves, despawns or reports a wall/base hit.
module bullet_engine #(
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] TankDir,
  output logic [8:0] tile_addr,
  input  logic [2:0] tile_data,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_active,
  output logic       wall_hit,
  output logic [8:0] wall_hit_addr,
  output logic [1:0] base_hit
);

  typedef enum logic [2:0] {IDLE, FLY, LOOKUP, WAIT, CHECK} state_t;

  localparam logic signed [10:0] SPD  = 11'(SPEED);
  localparam logic [7:0]         COOL = 8'(COOLDOWN);

  function automatic logic off_screen(input logic signed [10:0] x, input logic signed [10:0] y);
    return (x < 0) || (x > 11'sd639) || (y < 0) || (y > 11'sd479);
  endfunction

  function automatic logic [8:0] tile_index(input logic [3:0] row, input logic [4:0] col);
    return 9'(row) * 9'd20 + 9'(col);
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d;
  logic [9:0]  nx_q, nx_d, ny_q, ny_d;
  logic [8:0]  addr_q, addr_d;
  logic [2:0]  tile_q, tile_d;
  logic        act_q, act_d;
  logic        wall_q, wall_d;
  logic [8:0]  waddr_q, waddr_d;
  logic [1:0]  base_q, base_d;
  logic [7:0]  cool_q, cool_d;
  logic        pend_q, pend_d;
  logic        fire_prev_q, fire_prev_d;
  logic        arm_q, arm_d;

  logic signed [10:0] cx, cy, nx_s, ny_s;
  logic [9:0]         sx, sy;
  logic               fire_edge, despawn;

  // arm_q blocks a fire level already held when reset released
  assign fire_edge = fire & ~fire_prev_q & arm_q;

  always_comb begin
    cx   = signed'({1'b0, bx_q});
    cy   = signed'({1'b0, by_q});
    nx_s = cx;
    ny_s = cy;
    sx   = TankX;
    sy   = TankY;
    case (dir_q)
      2'd0:    ny_s = cy - SPD;
      2'd1:    nx_s = cx + SPD;
      2'd2:    ny_s = cy + SPD;
      default: nx_s = cx - SPD;
    endcase
    case (TankDir)
      2'd0:    sy = TankY - 10'd16;
      2'd1:    sx = TankX + 10'd16;
      2'd2:    sy = TankY + 10'd16;
      default: sx = TankX - 10'd16;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    bx_d        = bx_q;
    by_d        = by_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    addr_d      = addr_q;
    tile_d      = tile_q;
    act_d       = act_q;
    wall_d      = 1'b0;
    waddr_d     = waddr_q;
    base_d      = 2'b00;
    pend_d      = pend_q;
    fire_prev_d = fire;
    arm_d       = arm_q | ~fire;
    cool_d      = (frame_tick && cool_q != 8'd0) ? cool_q - 8'd1 : cool_q;
    despawn     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_tick && pend_q) begin
          dir_d   = TankDir;
          bx_d    = sx;
          by_d    = sy;
          act_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = FLY;
        end else if (fire_edge && cool_q == 8'd0) begin
          pend_d = 1'b1;
        end
      end
      FLY: begin
        if (frame_tick) begin
          if (off_screen(nx_s, ny_s)) begin
            despawn = 1'b1;
          end else begin
            nx_d    = nx_s[9:0];
            ny_d    = ny_s[9:0];
            addr_d  = tile_index(ny_s[8:5], nx_s[9:5]);
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: state_d = WAIT;
      WAIT: begin
        tile_d  = tile_data;
        state_d = CHECK;
      end
      CHECK: begin
        case (tile_q)
          3'd0: begin
            bx_d    = nx_q;
            by_d    = ny_q;
            state_d = FLY;
          end
          3'd2: begin
            wall_d  = 1'b1;
            waddr_d = addr_q;
            despawn = 1'b1;
          end
          3'd3: begin
            base_d  = 2'b01;
            despawn = 1'b1;
          end
          3'd4: begin
            base_d  = 2'b10;
            despawn = 1'b1;
          end
          default: despawn = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (despawn) begin
      act_d   = 1'b0;
      cool_d  = COOL;
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      dir_q       <= 2'd0;
      bx_q        <= 10'd0;
      by_q        <= 10'd0;
      nx_q        <= 10'd0;
      ny_q        <= 10'd0;
      addr_q      <= 9'd0;
      tile_q      <= 3'd0;
      act_q       <= 1'b0;
      wall_q      <= 1'b0;
      waddr_q     <= 9'd0;
      base_q      <= 2'b00;
      cool_q      <= 8'd0;
      pend_q      <= 1'b0;
      fire_prev_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      addr_q      <= addr_d;
      tile_q      <= tile_d;
      act_q       <= act_d;
      wall_q      <= wall_d;
      waddr_q     <= waddr_d;
      base_q      <= base_d;
      cool_q      <= cool_d;
      pend_q      <= pend_d;
      fire_prev_q <= fire_prev_d;
      arm_q       <= arm_d;
    end
  end

  assign tile_addr     = addr_q;
  assign BulletX       = bx_q;
  assign BulletY       = by_q;
  assign bullet_active = act_q;
  assign wall_hit      = wall_q;
  assign wall_hit_addr = waddr_q;
  assign base_hit      = base_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Bench for bullet_engine: a frame-level bullet model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bullet_engine;
  localparam int SPEED    = 4;
  localparam int COOLDOWN = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] TankX = 10'd0;
  logic [9:0] TankY = 10'd0;
  logic [1:0] TankDir = 2'd0;
  logic [2:0] tile_data = 3'd0;
  logic [8:0] tile_addr;
  logic [9:0] BulletX, BulletY;
  logic       bullet_active, wall_hit;
  logic [8:0] wall_hit_addr;
  logic [1:0] base_hit;

  logic [2:0] tmap [0:299];
  int n_cmp = 0;
  int n_err = 0;
  int spawns = 0;
  logic act_prev = 1'b0;

  always #5 Clk = ~Clk;

  bullet_engine #(.SPEED(SPEED), .COOLDOWN(COOLDOWN)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .fire(fire),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir),
    .tile_addr(tile_addr), .tile_data(tile_data),
    .BulletX(BulletX), .BulletY(BulletY), .bullet_active(bullet_active),
    .wall_hit(wall_hit), .wall_hit_addr(wall_hit_addr), .base_hit(base_hit)
  );

  // Map ROM with one cycle of read latency
  always @(posedge Clk) tile_data <= (tile_addr < 9'd300) ? tmap[tile_addr] : 3'd0;

  always @(posedge Clk) begin
    act_prev <= bullet_active;
    if (bullet_active && !act_prev) spawns <= spawns + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_dir, m_act, m_cool, m_pend, m_prev, m_armed, m_busy;
  int m_nx, m_ny, m_addr, m_wall, m_waddr, m_base, m_edge;

  function automatic int dx_of(input int d);
    return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
  endfunction
  function automatic int dy_of(input int d);
    return (d == 2) ? 1 : ((d == 0) ? -1 : 0);
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dir = 0; m_act = 0; m_cool = 0; m_pend = 0;
    m_prev = 0; m_armed = 0; m_busy = 0; m_nx = 0; m_ny = 0;
    m_addr = 0; m_wall = 0; m_waddr = 0; m_base = 0;
  endtask

  task automatic model_despawn();
    m_act = 0;
    m_cool = COOLDOWN;
  endtask

  task automatic model_step();
    m_edge = (fire && !m_prev && m_armed) ? 1 : 0;
    m_wall = 0;
    m_base = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        case (int'(tmap[m_addr]))
          0: begin m_x = m_nx; m_y = m_ny; end
          2: begin m_wall = 1; m_waddr = m_addr; model_despawn(); end
          3: begin m_base = 1; model_despawn(); end
          4: begin m_base = 2; model_despawn(); end
          default: model_despawn();
        endcase
      end
    end else if (m_act != 0) begin
      if (frame_tick) begin
        m_nx = m_x + SPEED * dx_of(m_dir);
        m_ny = m_y + SPEED * dy_of(m_dir);
        if (m_nx < 0 || m_nx > 639 || m_ny < 0 || m_ny > 479) model_despawn();
        else begin
          m_addr = (m_ny / 32) * 20 + (m_nx / 32);
          m_busy = 3;
        end
      end
    end else begin
      if (frame_tick && m_pend != 0) begin
        m_dir  = int'(TankDir);
        m_x    = (int'(TankX) + 16 * dx_of(m_dir)) & 1023;
        m_y    = (int'(TankY) + 16 * dy_of(m_dir)) & 1023;
        m_act  = 1;
        m_pend = 0;
      end else if (m_edge != 0 && m_cool == 0) begin
        m_pend = 1;
      end
      if (frame_tick && m_cool > 0) m_cool--;
    end
    if (!fire) m_armed = 1;
    m_prev = fire ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      chk("active", bullet_active, m_act);
      chk("bullet_x", BulletX, m_x);
      chk("bullet_y", BulletY, m_y);
      chk("tile_addr", tile_addr, m_addr);
      chk("wall_hit", wall_hit, m_wall);
      chk("base_hit", base_hit, m_base);
      if (m_wall != 0) chk("wall_addr", wall_hit_addr, m_waddr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic edge_fire();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(1);
  endtask

  task automatic wait_cool();
    repeat (COOLDOWN) begin
      pulse_tick();
      cyc(1);
    end
  endtask

  int s0;

  initial begin
    for (int i = 0; i < 300; i++) tmap[i] = 3'd0;
    TankX = 10'd320; TankY = 10'd240; TankDir = 2'd1;
    cyc(3);
    chk("rst_active", bullet_active, 0);
    chk("rst_x", BulletX, 0);
    chk("rst_addr", tile_addr, 0);
    Reset_n = 1'b1;
    cyc(2);

    // Spawn right, then one step to x=340 through tile 150
    edge_fire();
    pulse_tick();
    chk("spawn_x", BulletX, 336);
    chk("spawn_y", BulletY, 240);
    chk("spawn_active", bullet_active, 1);
    pulse_tick();
    chk("lookup_addr", tile_addr, 150);
    cyc(2);
    chk("hold_x", BulletX, 336);
    cyc(1);
    chk("commit_x", BulletX, 340);

    // Breakable wall ahead
    tmap[150] = 3'd2;
    pulse_tick();
    cyc(3);
    chk("wall_pulse", wall_hit, 1);
    chk("wall_addr_lit", wall_hit_addr, 150);
    chk("wall_despawn", bullet_active, 0);
    cyc(1);
    chk("wall_single", wall_hit, 0);
    tmap[150] = 3'd0;
    wait_cool();

    // P1 base below, then cooldown discards edges
    TankX = 10'd300; TankY = 10'd420; TankDir = 2'd2;
    tmap[269] = 3'd3;
    edge_fire();
    pulse_tick();
    chk("spawn_down_y", BulletY, 436);
    pulse_tick();
    chk("base_addr", tile_addr, 269);
    cyc(3);
    chk("base_p1", base_hit, 1);
    chk("base_no_wall", wall_hit, 0);
    cyc(1);
    chk("base_single", base_hit, 0);
    repeat (COOLDOWN) begin
      edge_fire();
      pulse_tick();
      chk("cool_noshot", bullet_active, 0);
    end
    pulse_tick();
    chk("cool_noqueue", bullet_active, 0);
    edge_fire();
    pulse_tick();
    chk("cool_refire", bullet_active, 1);
    pulse_tick();
    cyc(4);
    chk("base_again_despawn", bullet_active, 0);
    tmap[269] = 3'd0;
    wait_cool();

    // Off the left edge: no lookup, no pulse
    TankX = 10'd18; TankY = 10'd100; TankDir = 2'd3;
    edge_fire();
    pulse_tick();
    chk("spawn_left_x", BulletX, 2);
    pulse_tick();
    chk("oob_active", bullet_active, 0);
    chk("oob_addr_kept", tile_addr, 269);
    chk("oob_x_kept", BulletX, 2);
    wait_cool();

    // P2 base, then code 7 as border
    TankX = 10'd320; TankY = 10'd240; TankDir = 2'd3;
    tmap[149] = 3'd4;
    edge_fire();
    pulse_tick();
    pulse_tick();
    cyc(3);
    chk("base_p2", base_hit, 2);
    cyc(1);
    wait_cool();
    tmap[149] = 3'd7;
    edge_fire();
    pulse_tick();
    pulse_tick();
    cyc(3);
    chk("code7_despawn", bullet_active, 0);
    chk("code7_no_base", base_hit, 0);
    chk("code7_no_wall", wall_hit, 0);
    chk("code7_x_kept", BulletX, 304);
    tmap[149] = 3'd0;
    wait_cool();

    // Held fire gives one bullet; an edge during flight is not queued
    TankDir = 2'd0;
    s0 = spawns;
    fire = 1'b1;
    repeat (20) begin
      pulse_tick();
      cyc(4);
    end
    chk("held_one", spawns - s0, 1);
    chk("held_y", BulletY, 152);
    fire = 1'b0;
    cyc(1);
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    tmap[90] = 3'd1;
    pulse_tick();
    cyc(4);
    chk("border_despawn", bullet_active, 0);
    repeat (12) begin
      pulse_tick();
      cyc(1);
    end
    chk("no_second", spawns - s0, 1);
    chk("no_second_active", bullet_active, 0);
    tmap[90] = 3'd0;

    // Reset during WAIT aborts the pending wall hit
    TankDir = 2'd1;
    tmap[150] = 3'd2;
    edge_fire();
    pulse_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
    fire = 1'b1;
    Reset_n = 1'b0;
    #1;
    chk("arst_active", bullet_active, 0);
    chk("arst_x", BulletX, 0);
    chk("arst_y", BulletY, 0);
    chk("arst_addr", tile_addr, 0);
    chk("arst_wall", wall_hit, 0);
    chk("arst_base", base_hit, 0);
    cyc(3);
    Reset_n = 1'b1;
    repeat (3) begin
      pulse_tick();
      cyc(1);
    end
    chk("held_after_rst", bullet_active, 0);
    fire = 1'b0;
    cyc(1);
    edge_fire();
    pulse_tick();
    chk("refire_after_rst", bullet_active, 1);
    chk("refire_x", BulletX, 336);
    pulse_tick();
    cyc(4);
    tmap[150] = 3'd0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
